// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types for the systolic matmul pass sequencer.
// Holds the phase state type that the top module registers.
package systolic_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one systolic-array matmul pass: weight load, activation load,
// activation stream with output capture, output drain, then a one-cycle done.
//
// state  | meaning
// IDLE   | waiting for start, all enables low
// LOAD_W | weight rows 0..H-1 read from operand memory into weight buffer
// LOAD_A | weights written into array, activation rows H..2H-1 loaded
// STREAM | activations streamed; outputs captured for the last 2H cycles
// DRAIN  | result rows drained, res_idx walks 0..H-1
// DONE   | single-cycle completion pulse
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int ARRAYHEIGHT = 4,
    parameter int ARRAYWIDTH  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic weight_buffer_load_en,
    output logic weight_buffer_out_en,
    output logic write_weight_en,
    output logic input_buffer_load_en,
    output logic input_buffer_out_en,
    output logic output_buffer_load_en,
    output logic output_buffer_out_en,
    output logic mem_rd_en,
    output logic [$clog2(2*ARRAYHEIGHT)-1:0] mem_rd_addr,
    output logic [$clog2(ARRAYHEIGHT)-1:0]   res_idx
);

    localparam int H      = ARRAYHEIGHT;
    localparam int W      = ARRAYWIDTH;
    localparam int CNT_W  = $clog2(5*H + W + 1);
    localparam int ADDR_W = $clog2(2*H);
    localparam int IDX_W  = $clog2(H);

    // Last cnt value of each phase; cnt runs continuously across phases.
    localparam logic [CNT_W-1:0] LAST_W      = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] LAST_A      = CNT_W'(2*H - 1);
    localparam logic [CNT_W-1:0] LAST_S      = CNT_W'(4*H + W - 2);
    localparam logic [CNT_W-1:0] LAST_D      = CNT_W'(5*H + W - 2);
    localparam logic [CNT_W-1:0] OBL_START   = CNT_W'(2*H + W - 1);
    localparam logic [CNT_W-1:0] DRAIN_START = CNT_W'(4*H + W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (abort && state != ST_IDLE) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state <= ST_LOAD_W;
                    end
                    cnt <= '0;
                end
                ST_LOAD_W: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_W) state <= ST_LOAD_A;
                end
                ST_LOAD_A: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_A) state <= ST_STREAM;
                end
                ST_STREAM: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_S) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_D) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy                  = 1'b0;
        done                  = 1'b0;
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        output_buffer_load_en = 1'b0;
        output_buffer_out_en  = 1'b0;
        mem_rd_en             = 1'b0;
        mem_rd_addr           = '0;
        res_idx               = '0;
        case (state)
            ST_LOAD_W: begin
                busy                  = 1'b1;
                weight_buffer_load_en = 1'b1;
                mem_rd_en             = 1'b1;
                mem_rd_addr           = ADDR_W'(cnt);
            end
            ST_LOAD_A: begin
                busy                 = 1'b1;
                input_buffer_load_en = 1'b1;
                write_weight_en      = 1'b1;
                weight_buffer_out_en = 1'b1;
                mem_rd_en            = 1'b1;
                mem_rd_addr          = ADDR_W'(cnt);
            end
            ST_STREAM: begin
                busy                  = 1'b1;
                input_buffer_out_en   = 1'b1;
                output_buffer_load_en = (cnt >= OBL_START);
            end
            ST_DRAIN: begin
                busy                 = 1'b1;
                output_buffer_out_en = 1'b1;
                res_idx              = IDX_W'(cnt - DRAIN_START);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
